// File: rtl/detect_flow_cfg_pkg.sv
// Shared constants, FSM state encodings and register-value mapping for the
// detect_flow condition-table loader.
package detect_flow_cfg_pkg;

  localparam int unsigned REGS_PER_FLOW = 4;
  localparam int unsigned OFFSET_BIT    = 2;
  localparam int unsigned FLOW_W        = 96;

  localparam int unsigned SRC_IP_LSB   = 64;
  localparam int unsigned SRC_PORT_LSB = 48;
  localparam int unsigned DST_IP_LSB   = 16;
  localparam int unsigned DST_PORT_LSB = 0;

  // Loader FSM states
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWrReq  = 3'd1;
  localparam logic [2:0] StWrResp = 3'd2;
  localparam logic [2:0] StRdReq  = 3'd3;
  localparam logic [2:0] StRdResp = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  // Transaction engine states
  localparam logic [2:0] TxnIdle  = 3'd0;
  localparam logic [2:0] TxnAddr  = 3'd1;
  localparam logic [2:0] TxnBresp = 3'd2;
  localparam logic [2:0] TxnAr    = 3'd3;
  localparam logic [2:0] TxnRdata = 3'd4;

  function automatic logic [31:0] cfg_reg_value(input logic [FLOW_W-1:0] entry,
                                                 input logic [1:0]        sel);
    logic [31:0] val;
    val = '0;
    case (sel)
      2'd0:    val = entry[SRC_IP_LSB +: 32];
      2'd1:    val = {16'h0, entry[SRC_PORT_LSB +: 16]};
      2'd2:    val = entry[DST_IP_LSB +: 32];
      default: val = {16'h0, entry[DST_PORT_LSB +: 16]};
    endcase
    return val;
  endfunction

endpackage

// File: rtl/detect_flow_cfg_loader_axil_txn.sv
// Single-outstanding AXI4-Lite transaction engine: one write or one read per request,
// all AXI outputs registered.
module detect_flow_cfg_axil_txn
  import detect_flow_cfg_pkg::*;
#(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wr_req,
  input  logic                 i_rd_req,
  input  logic [AddrWidth-1:0] i_addr,
  input  logic [DataWidth-1:0] i_wdata,
  output logic                 o_ready,
  output logic                 o_wr_ack,
  output logic                 o_rd_ack,
  output logic                 o_rsp_valid,
  output logic [1:0]           o_rsp_resp,
  output logic [DataWidth-1:0] o_rsp_rdata,
  output logic [AddrWidth-1:0] o_awaddr,
  output logic                 o_awvalid,
  input  logic                 i_awready,
  output logic [DataWidth-1:0] o_wdata,
  output logic                 o_wvalid,
  input  logic                 i_wready,
  input  logic [1:0]           i_bresp,
  input  logic                 i_bvalid,
  output logic                 o_bready,
  output logic [AddrWidth-1:0] o_araddr,
  output logic                 o_arvalid,
  input  logic                 i_arready,
  input  logic [DataWidth-1:0] i_rdata,
  input  logic [1:0]           i_rresp,
  input  logic                 i_rvalid,
  output logic                 o_rready
);

  logic [2:0]           r_state;
  logic [AddrWidth-1:0] r_awaddr, r_araddr;
  logic [DataWidth-1:0] r_wdata;
  logic                 r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;

  logic w_aw_hs, w_w_hs, w_wr_ack;

  // AW and W retire independently; the write phase ends once both have.
  assign w_aw_hs  = r_awvalid & i_awready;
  assign w_w_hs   = r_wvalid & i_wready;
  assign w_wr_ack = (r_state == TxnAddr) && (!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs);

  always_comb begin
    o_ready     = (r_state == TxnIdle);
    o_wr_ack    = w_wr_ack;
    o_rd_ack    = (r_state == TxnAr) && i_arready;
    o_rsp_valid = ((r_state == TxnBresp) && i_bvalid) || ((r_state == TxnRdata) && i_rvalid);
    o_rsp_resp  = (r_state == TxnRdata) ? i_rresp : i_bresp;
    o_rsp_rdata = i_rdata;
  end

  assign o_awaddr  = r_awaddr;
  assign o_awvalid = r_awvalid;
  assign o_wdata   = r_wdata;
  assign o_wvalid  = r_wvalid;
  assign o_bready  = r_bready;
  assign o_araddr  = r_araddr;
  assign o_arvalid = r_arvalid;
  assign o_rready  = r_rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= TxnIdle;
      r_awaddr  <= '0;
      r_araddr  <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      case (r_state)
        TxnIdle: begin
          if (i_wr_req) begin
            r_awaddr  <= i_addr;
            r_wdata   <= i_wdata;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= TxnAddr;
          end else if (i_rd_req) begin
            r_araddr  <= i_addr;
            r_arvalid <= 1'b1;
            r_state   <= TxnAr;
          end
        end
        TxnAddr: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_wr_ack) begin
            r_bready <= 1'b1;
            r_state  <= TxnBresp;
          end
        end
        TxnBresp: begin
          if (i_bvalid) begin
            r_bready <= 1'b0;
            r_state  <= TxnIdle;
          end
        end
        TxnAr: begin
          if (i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= TxnRdata;
          end
        end
        TxnRdata: begin
          if (i_rvalid) begin
            r_rready <= 1'b0;
            r_state  <= TxnIdle;
          end
        end
        default: r_state <= TxnIdle;
      endcase
    end
  end

endmodule

// File: rtl/detect_flow_cfg_loader.sv
// Boot-time loader writing the detect_flow condition table over AXI4-Lite.
// Define DETECT_FLOW_CFG_VERIFY_EN to add a read-back compare pass after the writes.
module detect_flow_cfg_loader
  import detect_flow_cfg_pkg::*;
#(
  parameter int unsigned COND_NUM           = 15,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [COND_NUM*FLOW_W-1:0]      cond_table,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [5:0]                      err_index,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned NumRegs = COND_NUM * REGS_PER_FLOW;
  localparam logic [5:0]  LastIdx = 6'(NumRegs - 1);

  logic [2:0]                 r_state;
  logic [5:0]                 r_idx;
  logic [COND_NUM*FLOW_W-1:0] r_shadow;
  logic                       r_busy, r_done, r_error;
  logic [5:0]                 r_err_index;

  logic [5:0]                    w_cond;
  logic [1:0]                    w_sel;
  logic [FLOW_W-1:0]             w_entry;
  logic [31:0]                   w_reg_data;
  logic [C_M_AXI_ADDR_WIDTH-1:0] w_addr;
  logic                          w_last, w_wr_req, w_rd_req;
  logic                          w_eng_ready, w_wr_ack, w_rd_ack, w_rsp_valid;
  logic [1:0]                    w_rsp_resp;
  logic [C_M_AXI_DATA_WIDTH-1:0] w_rsp_rdata;

  assign w_cond     = r_idx / 6'(REGS_PER_FLOW);
  assign w_sel      = 2'(r_idx % 6'(REGS_PER_FLOW));
  assign w_entry    = r_shadow[32'(w_cond) * FLOW_W +: FLOW_W];
  assign w_reg_data = cfg_reg_value(w_entry, w_sel);
  assign w_addr     = C_M_AXI_ADDR_WIDTH'(r_idx) << OFFSET_BIT;
  assign w_last     = (r_idx == LastIdx);
  assign w_wr_req   = (r_state == StWrReq) && w_eng_ready;

`ifdef DETECT_FLOW_CFG_VERIFY_EN
  assign w_rd_req = (r_state == StRdReq) && w_eng_ready;
`else
  logic w_unused;
  assign w_rd_req = 1'b0;
  assign w_unused = ^{w_rd_ack, w_rsp_rdata};
`endif

  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign err_index    = r_err_index;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;

  detect_flow_cfg_axil_txn #(
    .AddrWidth(C_M_AXI_ADDR_WIDTH),
    .DataWidth(C_M_AXI_DATA_WIDTH)
  ) u_txn (
    .clk        (clk),
    .rst        (rst),
    .i_wr_req   (w_wr_req),
    .i_rd_req   (w_rd_req),
    .i_addr     (w_addr),
    .i_wdata    (C_M_AXI_DATA_WIDTH'(w_reg_data)),
    .o_ready    (w_eng_ready),
    .o_wr_ack   (w_wr_ack),
    .o_rd_ack   (w_rd_ack),
    .o_rsp_valid(w_rsp_valid),
    .o_rsp_resp (w_rsp_resp),
    .o_rsp_rdata(w_rsp_rdata),
    .o_awaddr   (M_AXI_AWADDR),
    .o_awvalid  (M_AXI_AWVALID),
    .i_awready  (M_AXI_AWREADY),
    .o_wdata    (M_AXI_WDATA),
    .o_wvalid   (M_AXI_WVALID),
    .i_wready   (M_AXI_WREADY),
    .i_bresp    (M_AXI_BRESP),
    .i_bvalid   (M_AXI_BVALID),
    .o_bready   (M_AXI_BREADY),
    .o_araddr   (M_AXI_ARADDR),
    .o_arvalid  (M_AXI_ARVALID),
    .i_arready  (M_AXI_ARREADY),
    .i_rdata    (M_AXI_RDATA),
    .i_rresp    (M_AXI_RRESP),
    .i_rvalid   (M_AXI_RVALID),
    .o_rready   (M_AXI_RREADY)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_shadow    <= cond_table;
            r_idx       <= '0;
            r_error     <= 1'b0;
            r_err_index <= '0;
            r_busy      <= 1'b1;
            r_state     <= StWrReq;
          end
        end
        StWrReq: if (w_wr_ack) r_state <= StWrResp;
        StWrResp: begin
          if (w_rsp_valid) begin
            if (w_rsp_resp != 2'b00) begin
              r_error     <= 1'b1;
              r_err_index <= r_idx;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= StDone;
            end else if (w_last) begin
`ifdef DETECT_FLOW_CFG_VERIFY_EN
              r_idx   <= '0;
              r_state <= StRdReq;
`else
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
`endif
            end else begin
              r_idx   <= r_idx + 6'd1;
              r_state <= StWrReq;
            end
          end
        end
`ifdef DETECT_FLOW_CFG_VERIFY_EN
        StRdReq: if (w_rd_ack) r_state <= StRdResp;
        StRdResp: begin
          if (w_rsp_valid) begin
            if ((w_rsp_resp != 2'b00) || (w_rsp_rdata != C_M_AXI_DATA_WIDTH'(w_reg_data))) begin
              r_error     <= 1'b1;
              r_err_index <= r_idx;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= StDone;
            end else if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_idx   <= r_idx + 6'd1;
              r_state <= StRdReq;
            end
          end
        end
`endif
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_detect_flow_cfg_loader.sv
// Directed bench for detect_flow_cfg_loader with a behavioural AXI4-Lite slave
// (configurable delays, BRESP fault and read-back corruption).
module tb_detect_flow_cfg_loader;

  localparam int unsigned CondNum = 15;
  localparam int unsigned TblW    = CondNum * 96;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start;
  logic [TblW-1:0] cond_table;
  logic            busy, done, error;
  logic [5:0]      err_index;
  logic [7:0]      awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [31:0]     wdata, rdata;
  logic [3:0]      wstrb;
  logic [1:0]      bresp, rresp;

  detect_flow_cfg_loader #(
    .COND_NUM(CondNum), .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cond_table(cond_table),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  // ---------------- slave model ----------------
  int          rand_en = 0, err_reg = -1, bad_rd_reg = -1;
  logic        log_clr;
  logic        aw_got, w_got, seen72;
  logic [7:0]  aw_addr_q;
  logic [31:0] w_data_q;
  int          aw_dly, w_dly, b_dly;
  logic [31:0] mem  [64];
  logic [31:0] wlog [64];
  logic [7:0]  alog [64];
  int          wr_cnt = 0, rd_cnt = 0, ovl_cnt = 0, aw_hs_cnt = 0;
  logic        aw_hs, w_hs, both_now;
  logic [7:0]  cur_addr;
  logic [31:0] cur_data;

  assign awready  = !aw_got && !bvalid && (aw_dly == 0);
  assign wready   = !w_got && !bvalid && (w_dly == 0);
  assign arready  = !rvalid;
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign both_now = (aw_got || aw_hs) && (w_got || w_hs);
  assign cur_addr = aw_got ? aw_addr_q : awaddr;
  assign cur_data = w_got ? w_data_q : wdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      aw_dly <= 0; w_dly <= 0; b_dly <= 0;
      rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
    end else begin
      if ((awvalid && (aw_got || bvalid)) || (wvalid && (w_got || bvalid))) ovl_cnt <= ovl_cnt + 1;
      if (awvalid && awaddr == 8'd72) seen72 <= 1'b1;
      if (aw_hs) begin
        aw_got <= 1'b1; aw_addr_q <= awaddr; aw_hs_cnt <= aw_hs_cnt + 1;
      end else if (awvalid && aw_dly > 0) aw_dly <= aw_dly - 1;
      if (w_hs) begin
        w_got <= 1'b1; w_data_q <= wdata;
      end else if (wvalid && w_dly > 0) w_dly <= w_dly - 1;
      if (both_now && !bvalid) begin
        if (b_dly == 0) begin
          bvalid <= 1'b1;
          bresp  <= (int'(cur_addr[7:2]) == err_reg) ? 2'b10 : 2'b00;
          mem[cur_addr[7:2]]  <= cur_data;
          wlog[wr_cnt[5:0]]   <= cur_data;
          alog[wr_cnt[5:0]]   <= cur_addr;
          wr_cnt <= wr_cnt + 1;
        end else b_dly <= b_dly - 1;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        aw_dly <= (rand_en != 0) ? int'($urandom_range(7)) : 0;
        w_dly  <= (rand_en != 0) ? int'($urandom_range(7)) : 0;
        b_dly  <= (rand_en != 0) ? int'($urandom_range(7)) : 0;
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1; rresp <= 2'b00; rd_cnt <= rd_cnt + 1;
        rdata  <= mem[araddr[7:2]] ^ ((int'(araddr[7:2]) == bad_rd_reg) ? 32'h1 : 32'h0);
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (log_clr) begin
        wr_cnt <= 0; rd_cnt <= 0; ovl_cnt <= 0; aw_hs_cnt <= 0; seen72 <= 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0, done_cnt = 0, done_cyc = 0, st_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end

  // ---------------- checking ----------------
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [TblW-1:0] t, input int r);
    logic [95:0] e;
    e = t[(r / 4) * 96 +: 96];
    case (r % 4)
      0:       return e[95:64];
      1:       return {16'h0, e[63:48]};
      2:       return e[47:16];
      default: return {16'h0, e[15:0]};
    endcase
  endfunction

  task automatic check_writes(input string tag, input logic [TblW-1:0] t);
    int bad = 0;
    for (int i = 0; i < 60; i++)
      if (wlog[i] !== exp_word(t, i) || alog[i] !== 8'(i * 4)) bad++;
    chk({tag, "_words"}, 64'(bad), 64'd0);
    chk({tag, "_count"}, 64'(wr_cnt), 64'd60);
  endtask

  task automatic log_clear();
    @(negedge clk); log_clr = 1'b1;
    @(negedge clk); log_clr = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    st_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < bound) begin
      @(negedge clk); n++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
  endtask

  logic [TblW-1:0] tbl_a, tbl_b;

  initial begin
    int n;
    int d0;
    tbl_a = '1;
    tbl_a[0 +: 96]       = {32'hC0A80102, 64'h0};
    tbl_a[14 * 96 +: 96] = {32'hC0A80101, 64'h0};
    tbl_b = {CondNum{96'h0A0B0C0D_1111_22334455_6666}};
    rst = 1'b1; start = 1'b0; log_clr = 1'b0; cond_table = tbl_a;
    repeat (3) @(negedge clk);
    chk("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("rst_addr", 64'({awaddr, araddr}), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_status", 64'({busy, done, error, err_index}), 64'd0);
    rst = 1'b0;

    // Zero-wait full load
    log_clear();
    do_start();
    chk("t2_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t2_first_aw", 64'({awvalid, wvalid, awaddr, wdata, wstrb}),
        64'({1'b1, 1'b1, 8'h00, 32'hC0A80102, 4'hF}));
    d0 = done_cnt;
    wait_done("t2", 400);
`ifndef DETECT_FLOW_CFG_VERIFY_EN
    chk("t2_done_cycle", 64'(done_cyc - st_cyc), 64'd180);
`endif
    repeat (3) @(negedge clk);
    chk("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t2_regs0_1", {wlog[0], wlog[1]}, {32'hC0A80102, 32'h0});
    chk("t2_regs2_3", {wlog[2], wlog[3]}, 64'h0);
    chk("t2_reg4", 64'(wlog[4]), 64'hFFFFFFFF);
    chk("t2_reg5", 64'(wlog[5]), 64'h0000FFFF);
    chk("t2_reg56", 64'(wlog[56]), 64'hC0A80101);
    check_writes("t2", tbl_a);
    chk("t2_err_busy", 64'({error, busy}), 64'd0);

    // Random ready/valid delays with AW/W skew
    rand_en = 1;
    cond_table = tbl_b;
    log_clear();
    do_start();
    wait_done("t3", 3000);
    check_writes("t3", tbl_b);
    chk("t3_overlap", 64'(ovl_cnt), 64'd0);
    chk("t3_aw_hs", 64'(aw_hs_cnt), 64'd60);
    chk("t3_error", 64'(error), 64'd0);
    rand_en = 0;

    // BRESP error on register 17
    err_reg = 17;
    cond_table = tbl_a;
    log_clear();
    do_start();
    wait_done("t4", 800);
    chk("t4_error", 64'(error), 64'd1);
    chk("t4_err_index", 64'(err_index), 64'd17);
    chk("t4_aw_hs", 64'(aw_hs_cnt), 64'd18);
    chk("t4_no_reg18", 64'(seen72), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    err_reg = -1;

    // Reset while waiting for B of register 30
    log_clear();
    do_start();
    n = 0;
    while (!(bready && awaddr == 8'd120) && n < 800) begin
      @(negedge clk); n++;
    end
    chk("t5_reach_reg30", 64'(n < 800), 64'd1);
    chk("t5_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("t5_rst_status", 64'({busy, done, error, err_index}), 64'd0);
    chk("t5_rst_addr", 64'({awaddr, wdata}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    log_clear();
    do_start();
    wait_done("t5", 800);
    check_writes("t5", tbl_a);
    chk("t5_error", 64'(error), 64'd0);

    // Start while busy and table change mid-load are ignored
    log_clear();
    cond_table = tbl_a;
    do_start();
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    cond_table = tbl_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6", 800);
    repeat (60) @(negedge clk);
    chk("t6_done_pulses", 64'(done_cnt - d0), 64'd1);
    check_writes("t6", tbl_a);
    chk("t6_busy", 64'(busy), 64'd0);

`ifdef DETECT_FLOW_CFG_VERIFY_EN
    // Read-back corruption on register 42
    bad_rd_reg = 42;
    cond_table = tbl_a;
    log_clear();
    do_start();
    wait_done("t7", 1200);
    chk("t7_error", 64'(error), 64'd1);
    chk("t7_err_index", 64'(err_index), 64'd42);
    chk("t7_reads", 64'(rd_cnt), 64'd43);
    bad_rd_reg = -1;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
